tick_scheduler: RTL
===================

Name: tick_scheduler

Overview:
Generates the redstone-tick enable that advances the compiled repeater/torch fabric, at a host-programmable rate.
Supports free-run, pause, and step-N-ticks execution.
Emits a pre-tick sample strobe so host I/O can be updated between ticks, and keeps a running tick count.
Sits between the host command interface and the clock-enable of the whole component fabric.

Parameters:
DIV_W, 24, width of tick period register/divider counter
STEP_W, 16, width of step-count argument and remaining-step counter
CNT_W, 32, width of executed-tick counter
PERIOD_DEF, 4, period in i_clk cycles loaded at reset (must be >= 2)

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_cmd_valid  in  1  command present
o_cmd_ready  out  1  command accepted when valid & ready
i_cmd_op  in  3  000 PAUSE, 001 RUN, 010 STEP, 011 SET_PERIOD, 100 CLR_COUNT, others NOP
i_cmd_arg  in  DIV_W  period (SET_PERIOD) or step count in low STEP_W bits (STEP)
o_tick  out  1  one-cycle fabric tick enable
o_io_sample  out  1  one-cycle strobe, one cycle before each o_tick
o_running  out  1  state is RUN
o_busy  out  1  state is RUN or STEP
o_step_done  out  1  one-cycle pulse when a STEP completes
o_tick_count  out  CNT_W  ticks issued since reset/clear

Behaviour:
- Reset values:
  - state = IDLE; period P = PERIOD_DEF; divider = 0; remaining = 0; tick_count = 0.
  - All strobes = 0; o_cmd_ready = 1.
- States:
  - IDLE: divider held at 0; no ticks.
  - RUN: divider counts 0..P-1 and wraps.
  - STEP: counts like RUN; remaining decrements on each tick.
- o_tick = busy & (divider == P-1). o_io_sample = busy & (divider == P-2). Both are decoded from registers, with no combinational path from cmd inputs.
- o_cmd_ready = 1 in IDLE and RUN, and 0 in STEP. STEP cannot be interrupted except by reset.
- Command effects (apply on the accept edge):
  - RUN: state = RUN; divider = 0. Accept at cycle k gives the first o_io_sample at k+P-1 and the first o_tick at k+P. RUN while already in RUN restarts the divider.
  - PAUSE: state = IDLE; divider = 0. If o_tick is high in the accept cycle, that tick still counts. No further ticks.
  - STEP N:
    - N = 0: state stays IDLE, and o_step_done pulses at k+1.
    - N > 0: state = STEP; remaining = N; divider = 0. Ticks occur at k+P, k+2P, ... k+N·P.
    - On the tick with remaining == 1: state goes to IDLE, and o_step_done pulses the following cycle (k+N·P+1). o_cmd_ready returns high in that same cycle.
    - STEP accepted in RUN switches to STEP mode with divider = 0.
  - SET_PERIOD A:
    - P = max(A, 2); divider = 0; state unchanged.
    - In RUN, the next tick occurs at k+P_new.
  - CLR_COUNT: tick_count = 0. If a tick occurs in the same cycle, the result is 0 (clear wins); state unchanged.
  - NOP: accepted, no effect.
- tick_count increments on each o_tick cycle and is visible the next cycle. It wraps modulo 2^CNT_W without saturation.
- P is at least 2 at all times, so o_io_sample always precedes o_tick by exactly 1 cycle. The clamp also applies to PERIOD_DEF if it is misconfigured.
- Reset mid-operation: state goes to IDLE immediately. No o_tick or o_step_done is produced in the cycle after reset. P returns to PERIOD_DEF.

Test Plan:
- Reset, then RUN at cycle 10 with P=4 -> o_io_sample at 13,17,21; o_tick at 14,18,22; o_tick_count=3 at cycle 23; o_running=1.
- SET_PERIOD 1 in IDLE, then STEP 3 at cycle 0 -> P clamps to 2; ticks at 2,4,6; o_cmd_ready=0 during 1..6; o_step_done at 7; o_busy=0 at 7.
- STEP 0 -> no o_tick; o_step_done at k+1; state stays IDLE.
- RUN with P=5, then PAUSE accepted in the same cycle as o_tick -> that tick counts (count +1); no further o_tick for 20 cycles; divider at 0.
- Preload tick_count near 2^CNT_W-1 (or use CNT_W=4), run 17 ticks -> count wraps to 1. CLR_COUNT coincident with a tick -> count reads 0.
- Assert i_reset mid-STEP (remaining=2) -> next cycle o_busy=0, o_tick=0, o_step_done=0, P=PERIOD_DEF, o_tick_count=0.

Source files
------------

// File: rtl/tick_scheduler.sv
// tick_scheduler: programmable-rate tick enable with run/pause/step-N control and tick counter
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready/i_cmd_op/i_cmd_arg   host command handshake
//   o_tick                one-cycle fabric tick enable
//   o_io_sample           one-cycle strobe one cycle before each o_tick
//   o_running, o_busy     state is RUN / state is RUN or STEP
//   o_step_done           one-cycle pulse after a STEP completes
//   o_tick_count          ticks issued since reset or clear
module tick_scheduler #(
    parameter int DIV_W      = 24,
    parameter int STEP_W     = 16,
    parameter int CNT_W      = 32,
    parameter int PERIOD_DEF = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [2:0]       i_cmd_op,
    input  logic [DIV_W-1:0] i_cmd_arg,
    output logic             o_tick,
    output logic             o_io_sample,
    output logic             o_running,
    output logic             o_busy,
    output logic             o_step_done,
    output logic [CNT_W-1:0] o_tick_count
);
    typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;
    localparam logic [DIV_W-1:0] P_RST = DIV_W'(PERIOD_DEF < 2 ? 2 : PERIOD_DEF);
    state_t state;
    logic [DIV_W-1:0] period, divider;
    logic [STEP_W-1:0] remaining, step_n;
    logic step_done, busy, accept;
    assign busy = state != IDLE;
    assign o_tick = busy && divider == period - DIV_W'(1);
    assign o_io_sample = busy && divider == period - DIV_W'(2);
    assign o_cmd_ready = state != STEP;
    assign o_running = state == RUN;
    assign o_busy = busy;
    assign o_step_done = step_done;
    assign accept = i_cmd_valid && o_cmd_ready;
    assign step_n = i_cmd_arg[STEP_W-1:0];
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
            period <= P_RST;
            divider <= '0;
            remaining <= '0;
            step_done <= 1'b0;
            o_tick_count <= '0;
        end else begin
            step_done <= 1'b0;
            o_tick_count <= o_tick_count + CNT_W'(o_tick);
            if (busy) divider <= o_tick ? '0 : divider + DIV_W'(1);
            if (state == STEP && o_tick) begin
                remaining <= remaining - STEP_W'(1);
                if (remaining == STEP_W'(1)) begin
                    state <= IDLE;
                    step_done <= 1'b1;
                end
            end
            if (accept) begin
                case (i_cmd_op)
                    3'b000: begin
                        state <= IDLE;
                        divider <= '0;
                    end
                    3'b001: begin
                        state <= RUN;
                        divider <= '0;
                    end
                    3'b010: begin
                        // a zero-length step completes immediately without leaving IDLE
                        state <= step_n == '0 ? IDLE : STEP;
                        remaining <= step_n;
                        divider <= '0;
                        step_done <= step_n == '0;
                    end
                    3'b011: begin
                        period <= i_cmd_arg < DIV_W'(2) ? DIV_W'(2) : i_cmd_arg;
                        divider <= '0;
                    end
                    3'b100: o_tick_count <= '0;
                    default: ;
                endcase
            end
        end
    end
endmodule
